// File: rtl/tl_grant_pkg.sv
// -----------------------------------------------------------------------------
// Package: tl_grant_pkg
// Purpose: TileLink Grant-channel type encodings, the grant tracker state
//          encoding, and decode helpers shared by the Grant consumer logic.
// Contents:
//   G_* localparams   builtin and non-builtin g_type encodings
//   state_t           S_IDLE / S_BEATS
//   grant_has_data()      grant carries data beats
//   grant_is_multibeat()  grant carries a full block of beats
//   grant_needs_finish()  grant must be acknowledged with a Finish
// -----------------------------------------------------------------------------
package tl_grant_pkg;

  // Builtin (uncached) grant types
  localparam logic [3:0] G_VOLUNTARY_ACK  = 4'd0;
  localparam logic [3:0] G_PREFETCH_ACK   = 4'd1;
  localparam logic [3:0] G_PUT_ACK        = 4'd3;
  localparam logic [3:0] G_GET_DATA_BEAT  = 4'd4;
  localparam logic [3:0] G_GET_DATA_BLOCK = 4'd5;

  // Non-builtin (cached) grant types
  localparam logic [3:0] G_SHARED         = 4'd0;
  localparam logic [3:0] G_EXCLUSIVE      = 4'd1;
  localparam logic [3:0] G_EXCLUSIVE_ACK  = 4'd2;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BEATS = 1'b1
  } state_t;

  function automatic logic grant_has_data(input logic is_builtin, input logic [3:0] g_type);
    logic r;
    if (is_builtin) begin
      r = (g_type == G_GET_DATA_BEAT) || (g_type == G_GET_DATA_BLOCK);
    end else begin
      r = (g_type == G_SHARED) || (g_type == G_EXCLUSIVE);
    end
    return r;
  endfunction

  function automatic logic grant_is_multibeat(input logic is_builtin, input logic [3:0] g_type);
    return grant_has_data(is_builtin, g_type) &&
           !(is_builtin && (g_type == G_GET_DATA_BEAT));
  endfunction

  function automatic logic grant_needs_finish(input logic is_builtin, input logic [3:0] g_type);
    return !(is_builtin && (g_type == G_VOLUNTARY_ACK));
  endfunction

endpackage

// File: rtl/grant_finish_tracker.sv
// -----------------------------------------------------------------------------
// Module: grant_finish_tracker
// Purpose: Consumes TileLink Grant beats from the single-entry Grant queue,
//          writes data beats straight into the refill array, counts the beats
//          of multi-beat blocks, pulses a completion report towards the
//          MSHR/uncached tracker and holds a Finish message for every grant
//          that needs acknowledgement.
// Configuration macro: GRANT_BEAT_CHECK_EN
//   defined   -> io_beat_err flags out-of-order addr_beat or a client id change
//                inside a block (sticky until reset)
//   undefined -> io_beat_err is tied low
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   io_grant_*                 Grant beat input (valid/ready handshake)
//   io_refill_*                refill-array write port, zero latency, no stall
//   io_done_*                  one-cycle completion pulse with client id
//   io_finish_*                Finish output (valid/ready handshake)
//   io_beat_err                sticky protocol-error flag
// -----------------------------------------------------------------------------
module grant_finish_tracker #(
  parameter int BEATS  = 8,
  parameter int BEAT_W = 3,
  parameter int DATA_W = 64,
  parameter int CXID_W = 2,
  parameter int MXID_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              io_grant_ready,
  input  logic              io_grant_valid,
  input  logic [BEAT_W-1:0] io_grant_bits_addr_beat,
  input  logic [CXID_W-1:0] io_grant_bits_client_xact_id,
  input  logic [MXID_W-1:0] io_grant_bits_manager_xact_id,
  input  logic              io_grant_bits_is_builtin_type,
  input  logic [3:0]        io_grant_bits_g_type,
  input  logic [DATA_W-1:0] io_grant_bits_data,
  output logic              io_refill_valid,
  output logic [BEAT_W-1:0] io_refill_addr_beat,
  output logic [DATA_W-1:0] io_refill_data,
  output logic              io_done_valid,
  output logic [CXID_W-1:0] io_done_client_xact_id,
  input  logic              io_finish_ready,
  output logic              io_finish_valid,
  output logic [MXID_W-1:0] io_finish_bits_manager_xact_id,
  output logic              io_beat_err
);
  import tl_grant_pkg::*;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t            state_r, state_nxt_s;
  logic [BEAT_W-1:0] beat_cnt_r, beat_cnt_nxt_s;
  logic [CXID_W-1:0] cxid_lat_r, cxid_lat_nxt_s;
  logic [MXID_W-1:0] mxid_lat_r, mxid_lat_nxt_s;
  logic              fin_pending_r, fin_pending_nxt_s;
  logic [MXID_W-1:0] fin_mxid_r, fin_mxid_nxt_s;
  logic              done_valid_r;
  logic [CXID_W-1:0] done_cxid_r, done_cxid_nxt_s;

  logic              accept_s;
  logic              has_data_s;
  logic              multibeat_s;
  logic              needs_fin_s;
  logic              complete_s;
  logic [CXID_W-1:0] cmpl_cxid_s;
  logic [MXID_W-1:0] cmpl_mxid_s;

  assign has_data_s  = grant_has_data(io_grant_bits_is_builtin_type, io_grant_bits_g_type);
  assign multibeat_s = grant_is_multibeat(io_grant_bits_is_builtin_type, io_grant_bits_g_type);
  assign needs_fin_s = grant_needs_finish(io_grant_bits_is_builtin_type, io_grant_bits_g_type);

  // Gating with reset keeps every valid/ready low while reset is held, and the
  // finish_ready term lets a new grant enter in the same cycle the Finish leaves.
  assign io_grant_ready = reset & (!fin_pending_r | io_finish_ready);
  assign accept_s       = io_grant_valid & io_grant_ready;

  // Refill writes go out in the accept cycle; the array never stalls.
  assign io_refill_valid     = accept_s & has_data_s;
  assign io_refill_addr_beat = io_grant_bits_addr_beat;
  assign io_refill_data      = io_grant_bits_data;

  // Next-state, beat counter and completion detection
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    cxid_lat_nxt_s = cxid_lat_r;
    mxid_lat_nxt_s = mxid_lat_r;
    complete_s     = 1'b0;
    cmpl_cxid_s    = io_grant_bits_client_xact_id;
    cmpl_mxid_s    = io_grant_bits_manager_xact_id;
    case (state_r)
      S_IDLE: begin
        if (accept_s && multibeat_s) begin
          state_nxt_s    = S_BEATS;
          beat_cnt_nxt_s = BEAT_W'(1);
          cxid_lat_nxt_s = io_grant_bits_client_xact_id;
          mxid_lat_nxt_s = io_grant_bits_manager_xact_id;
        end else if (accept_s) begin
          complete_s = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_BEATS: begin
        // The block completes with the ids latched at its first beat.
        if (accept_s && (beat_cnt_r == LAST_BEAT)) begin
          state_nxt_s    = S_IDLE;
          beat_cnt_nxt_s = '0;
          complete_s     = 1'b1;
          cmpl_cxid_s    = cxid_lat_r;
          cmpl_mxid_s    = mxid_lat_r;
        end else if (accept_s) begin
          beat_cnt_nxt_s = beat_cnt_r + BEAT_W'(1);
        end else begin
          state_nxt_s = S_BEATS;
        end
      end
      default: begin
        state_nxt_s    = S_IDLE;
        beat_cnt_nxt_s = '0;
      end
    endcase
  end

  // Finish bookkeeping: a new completion wins over a same-cycle handshake so
  // the outgoing Finish is consumed and the new one takes its place.
  always_comb begin
    fin_pending_nxt_s = fin_pending_r;
    fin_mxid_nxt_s    = fin_mxid_r;
    done_cxid_nxt_s   = done_cxid_r;
    if (complete_s && needs_fin_s) begin
      fin_pending_nxt_s = 1'b1;
      fin_mxid_nxt_s    = cmpl_mxid_s;
    end else if (fin_pending_r && io_finish_ready) begin
      fin_pending_nxt_s = 1'b0;
    end else begin
      fin_pending_nxt_s = fin_pending_r;
    end
    if (complete_s) begin
      done_cxid_nxt_s = cmpl_cxid_s;
    end else begin
      done_cxid_nxt_s = done_cxid_r;
    end
  end

  // State, counter, latched ids, completion pulse and Finish registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      beat_cnt_r    <= '0;
      cxid_lat_r    <= '0;
      mxid_lat_r    <= '0;
      fin_pending_r <= 1'b0;
      fin_mxid_r    <= '0;
      done_valid_r  <= 1'b0;
      done_cxid_r   <= '0;
    end else begin
      state_r       <= state_nxt_s;
      beat_cnt_r    <= beat_cnt_nxt_s;
      cxid_lat_r    <= cxid_lat_nxt_s;
      mxid_lat_r    <= mxid_lat_nxt_s;
      fin_pending_r <= fin_pending_nxt_s;
      fin_mxid_r    <= fin_mxid_nxt_s;
      done_valid_r  <= complete_s;
      done_cxid_r   <= done_cxid_nxt_s;
    end
  end

  assign io_done_valid                  = done_valid_r;
  assign io_done_client_xact_id         = done_cxid_r;
  assign io_finish_valid                = fin_pending_r;
  assign io_finish_bits_manager_xact_id = fin_mxid_r;

`ifdef GRANT_BEAT_CHECK_EN
  logic beat_err_r;
  logic chk_beat_s;
  logic bad_beat_s;

  // Only beats belonging to a block are order-checked; a lone GET_DATA_BEAT
  // legitimately carries any addr_beat.
  assign chk_beat_s = accept_s && ((state_r == S_BEATS) || multibeat_s);
  assign bad_beat_s = (io_grant_bits_addr_beat != beat_cnt_r) ||
                      ((state_r == S_BEATS) && (io_grant_bits_client_xact_id != cxid_lat_r));

  // Sticky protocol-error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_err_r <= 1'b0;
    end else if (chk_beat_s && bad_beat_s) begin
      beat_err_r <= 1'b1;
    end else begin
      beat_err_r <= beat_err_r;
    end
  end

  assign io_beat_err = beat_err_r;
`else
  assign io_beat_err = 1'b0;
`endif

endmodule
